bus_arbiter: RTL and testbench

Round-robin arbiter that shares one external bus master port between `N_MASTERS` cores in multi-core builds. Each `RISC_V_` instance exposes its `BUS_M` bundle to one request slot. The arbiter forwards exactly one transaction at a time to the shared slave side and routes the acknowledge back to the requester that owns it. A lock mechanism keeps the bus with one hart across an `__ATOMIC` LR/SC sequence.

---
 rtl/arvi_bus_pkg.sv | 12 +
 rtl/rr_picker.sv | 31 +++
 rtl/bus_arbiter.sv | 115 +++++++++++
 tb/tb_bus_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arvi_bus_pkg.sv
// Shared bus types and constants for the multi-core bus arbiter.
package arvi_bus_pkg;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first asserted request at or above rr_ptr, wrapping mod N.
module rr_picker #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [N_MASTERS-1:0] rot;
  logic [IDX_W-1:0]     enc;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    // Rotate so rr_ptr lands at bit 0, priority-encode the lowest bit, then rotate the index back.
    rot = N_MASTERS'({req, req} >> rr_ptr);
    enc = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    sum = SUM_W'(enc) + SUM_W'(rr_ptr);
    if (sum >= SUM_W'(N_MASTERS)) sum = sum - SUM_W'(N_MASTERS);
    idx = sum[IDX_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus master port between N cores, with an atomic lock to hold the bus.
module bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS-1:0]      i_m_bus_en,
  input  logic [N_MASTERS-1:0]      i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*BE_W-1:0] i_m_byte_en,
  input  logic [N_MASTERS-1:0]      i_m_lock,
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [XLEN-1:0]           o_m_rd_data,
  output logic                      o_bus_en,
  output logic                      o_wr_en,
  output logic [XLEN-1:0]           o_wr_data,
  output logic [XLEN-1:0]           o_addr,
  output logic [BE_W-1:0]           o_byte_en,
  input  logic                      i_ack,
  input  logic [XLEN-1:0]           i_rd_data,
  output logic                      o_grant_valid,
  output logic [IDX_W-1:0]          o_grant_idx
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             busy;
  logic             own_req;
  logic             own_lock;

  rr_picker #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req    (i_m_bus_en),
    .rr_ptr (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          grant_d = pick_idx;
          ptr_d   = (pick_idx == IDX_W'(N_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      BUSY: begin
        if (i_ack) state_d = own_lock ? LOCKED : IDLE;
      end
      // Only the lock holder may re-enter BUSY; the round-robin pointer stays put.
      LOCKED: begin
        if (own_req) state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

  // Request mux toward the slave and ack demux back to the owner.
  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    o_wr_en   = 1'b0;
    o_wr_data = '0;
    o_addr    = '0;
    o_byte_en = '0;
    o_m_ack   = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (grant_q == IDX_W'(i)) begin
        own_req  = i_m_bus_en[i];
        own_lock = i_m_lock[i];
        if (busy) begin
          o_wr_en    = i_m_wr_en[i];
          o_wr_data  = i_m_wr_data[i*XLEN +: XLEN];
          o_addr     = i_m_addr[i*XLEN +: XLEN];
          o_byte_en  = i_m_byte_en[i*BE_W +: BE_W];
          o_m_ack[i] = i_ack;
        end
      end
    end
  end

  assign o_bus_en      = busy;
  assign o_grant_valid = busy;
  assign o_grant_idx   = grant_q;
  assign o_m_rd_data   = i_rd_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter with two masters.
module tb_bus_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_bus_en;
  logic [N-1:0]    m_wr_en;
  logic [N*32-1:0] m_wr_data;
  logic [N*32-1:0] m_addr;
  logic [N*4-1:0]  m_byte_en;
  logic [N-1:0]    m_lock;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rd_data;
  logic            bus_en;
  logic            wr_en;
  logic [31:0]     wr_data;
  logic [31:0]     addr;
  logic [3:0]      byte_en;
  logic            ack;
  logic [31:0]     rd_data;
  logic            grant_valid;
  logic [0:0]      grant_idx;

  bus_arbiter #(.N_MASTERS(N), .XLEN(XLEN)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_m_bus_en    (m_bus_en),
    .i_m_wr_en     (m_wr_en),
    .i_m_wr_data   (m_wr_data),
    .i_m_addr      (m_addr),
    .i_m_byte_en   (m_byte_en),
    .i_m_lock      (m_lock),
    .o_m_ack       (m_ack),
    .o_m_rd_data   (m_rd_data),
    .o_bus_en      (bus_en),
    .o_wr_en       (wr_en),
    .o_wr_data     (wr_data),
    .o_addr        (addr),
    .o_byte_en     (byte_en),
    .i_ack         (ack),
    .i_rd_data     (rd_data),
    .o_grant_valid (grant_valid),
    .o_grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  lock;
    logic        ack;
    logic [31:0] rd;
    logic        exp_bus_en;
    logic [1:0]  exp_ack;
    logic        exp_grant;
  } vec_t;

  vec_t vq[$];

  logic [31:0] addr_c [2];
  logic [31:0] data_c [2];
  logic [3:0]  be_c   [2];
  logic        wr_c   [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int v, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %h expected %h", v, nm, act, exp);
    end
  endtask

  task automatic check_vec(input int v, input logic eb, input logic [1:0] ea, input logic eg);
    int g;
    g = int'(eg);
    check("bus_en", v, 32'(bus_en), 32'(eb));
    check("grant_valid", v, 32'(grant_valid), 32'(eb));
    check("grant_idx", v, 32'(grant_idx), 32'(eg));
    check("m_ack", v, 32'(m_ack), 32'(ea));
    check("addr", v, addr, eb ? addr_c[g] : 32'h0);
    check("wr_data", v, wr_data, eb ? data_c[g] : 32'h0);
    check("byte_en", v, 32'(byte_en), eb ? 32'(be_c[g]) : 32'h0);
    check("wr_en", v, 32'(wr_en), eb ? 32'(wr_c[g]) : 32'h0);
  endtask

  initial begin
    addr_c[0] = 32'h0000_0100; data_c[0] = 32'hAAAA_5555; be_c[0] = 4'hF; wr_c[0] = 1'b0;
    addr_c[1] = 32'h8000_0010; data_c[1] = 32'h0000_1234; be_c[1] = 4'h3; wr_c[1] = 1'b1;
    m_addr    = {addr_c[1], addr_c[0]};
    m_wr_data = {data_c[1], data_c[0]};
    m_byte_en = {be_c[1], be_c[0]};
    m_wr_en   = {wr_c[1], wr_c[0]};

    //          req    lock   ack   rd            bus  ack    grant
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0}); // c0 IDLE picks 0
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b1, 2'b00, 1'b0});
    vq.push_back('{2'b11, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 2'b01, 1'b0});
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0}); // IDLE picks 1
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b1, 2'b00, 1'b1});
    vq.push_back('{2'b11, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 2'b10, 1'b1});
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b1}); // IDLE picks 0
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b1, 2'b00, 1'b0});
    vq.push_back('{2'b11, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 2'b01, 1'b0});
    vq.push_back('{2'b00, 2'b00, 1'b1, 32'h5555_0000, 1'b0, 2'b00, 1'b0}); // stray ack in IDLE
    vq.push_back('{2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0});
    vq.push_back('{2'b01, 2'b01, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0}); // m0 alone, ptr=1
    vq.push_back('{2'b01, 2'b01, 1'b1, 32'hDEADBEEF, 1'b1, 2'b01, 1'b0}); // ack with lock
    vq.push_back('{2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0}); // LOCKED ignores m1
    vq.push_back('{2'b10, 2'b00, 1'b1, 32'h0,        1'b0, 2'b00, 1'b0}); // stray ack in LOCKED
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0}); // owner wins despite ptr=1
    vq.push_back('{2'b11, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 2'b01, 1'b0}); // unlocked access
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0}); // IDLE picks 1
    vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        1'b1, 2'b00, 1'b1}); // m1 write
    vq.push_back('{2'b11, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 2'b10, 1'b1});
    vq.push_back('{2'b01, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 1'b1});
    vq.push_back('{2'b01, 2'b00, 1'b1, 32'hDEADBEEF, 1'b1, 2'b01, 1'b0}); // ack in first BUSY cycle

    // Reset with every master requesting and a stray slave ack.
    rst = 1'b1; m_bus_en = 2'b11; m_lock = 2'b00; ack = 1'b1; rd_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_vec(-1, 1'b0, 2'b00, 1'b0);
    rst = 1'b0; ack = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      m_bus_en = vq[i].req;
      m_lock   = vq[i].lock;
      ack      = vq[i].ack;
      rd_data  = vq[i].rd;
      @(negedge clk);
      check_vec(i, vq[i].exp_bus_en, vq[i].exp_ack, vq[i].exp_grant);
      if (vq[i].ack && vq[i].exp_bus_en) check("rd_data", i, m_rd_data, vq[i].rd);
      @(posedge clk);
      #1;
    end

    // Reset mid-BUSY with m0 granted (rr_ptr is 1 at that point).
    m_bus_en = 2'b01; ack = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pre_bus_en", 100, 32'(bus_en), 32'h1);
    ack = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_bus_en", 101, 32'(bus_en), 32'h0);
    check("rst_async_ack", 101, 32'(m_ack), 32'h0);
    check("rst_async_valid", 101, 32'(grant_valid), 32'h0);
    rst = 1'b0; ack = 1'b0; m_bus_en = 2'b11;
    @(negedge clk);
    check("post_rst_idle", 102, 32'(bus_en), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_vec(103, 1'b1, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
